// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Gathers finished results from UNITS execution units and serialises them
// onto the single common data bus (CDB). The bus delivers at most one result
// per cycle. Each unit owns a one-entry holding buffer. A round-robin grant
// picks which full buffer drives the bus next.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   result_valid  per unit: a result is being presented
//   result_ready  per unit: the result is taken this cycle (combinational)
//   result_rs_id  per unit: tag of the reservation station that produced it
//   result_value  per unit: result value
//   cdb_valid     one-cycle broadcast strobe, no backpressure
//   cdb_rs_id     tag of the broadcast result (held while idle)
//   cdb_value     broadcast value (held while idle)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int UNITS         = 4,
  parameter int OPERAND_WIDTH = 32,
  parameter int RS_ID_WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     result_valid [UNITS],
  output logic                     result_ready [UNITS],
  input  logic [RS_ID_WIDTH-1:0]   result_rs_id [UNITS],
  input  logic [OPERAND_WIDTH-1:0] result_value [UNITS],
  output logic                     cdb_valid,
  output logic [RS_ID_WIDTH-1:0]   cdb_rs_id,
  output logic [OPERAND_WIDTH-1:0] cdb_value
);

  localparam int PTR_W = $clog2(UNITS);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e               state_q   [UNITS];
  buf_state_e               state_d   [UNITS];
  logic [RS_ID_WIDTH-1:0]   buf_rs_id [UNITS];
  logic [OPERAND_WIDTH-1:0] buf_value [UNITS];

  logic [UNITS-1:0] full;
  logic [UNITS-1:0] grant;
  logic [UNITS-1:0] ready;
  logic [UNITS-1:0] accept;
  logic             any_grant;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] ptr;

  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      full[u] = (state_q[u] == BUF_FULL);
    end
  end

  // Round-robin search that starts at the pointer and wraps. The grant is
  // derived only from registered buffer state, so a result that arrives this
  // cycle can never be granted in the same cycle.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < UNITS; i++) begin
      idx = PTR_W'((int'(ptr) + i) % UNITS);
      if (!any_grant && full[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

  // A buffer being drained this cycle can take a new result at once, so a
  // unit that is the only requester streams one result per cycle.
  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      ready[u]        = ~full[u] | grant[u];
      accept[u]       = result_valid[u] & ready[u];
      result_ready[u] = ready[u];
    end
  end

  // Per-unit buffer next state. A FULL buffer can only accept while it is
  // granted, which is the reload case and keeps it FULL.
  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      state_d[u] = state_q[u];
      case (state_q[u])
        BUF_EMPTY: if (accept[u])             state_d[u] = BUF_FULL;
        BUF_FULL:  if (grant[u] && !accept[u]) state_d[u] = BUF_EMPTY;
      endcase
    end
  end

  // Buffer state and payload registers. Data is sampled only on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int u = 0; u < UNITS; u++) begin
        state_q[u]   <= BUF_EMPTY;
        buf_rs_id[u] <= '0;
        buf_value[u] <= '0;
      end
    end else begin
      for (int u = 0; u < UNITS; u++) begin
        state_q[u] <= state_d[u];
        if (accept[u]) begin
          buf_rs_id[u] <= result_rs_id[u];
          buf_value[u] <= result_value[u];
        end
      end
    end
  end

  // The pointer moves to the unit just after the winner, giving every
  // continuously full buffer exactly one grant per UNITS cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (grant_idx == PTR_W'(UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Registered bus. The payload holds while idle; only the strobe drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_rs_id <= '0;
      cdb_value <= '0;
    end else begin
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_rs_id <= buf_rs_id[grant_idx];
        cdb_value <= buf_value[grant_idx];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Drives per-unit result streams into cdb_arbiter. A behavioural model of
// the holding buffers and round-robin pointer decides, for every cycle,
// which results are taken and which unit wins the bus. Each win pushes the
// expected broadcast to a queue, which is popped when the bus should show it.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int UNITS     = 4;
  localparam int OW        = 32;
  localparam int RW        = 5;
  localparam int SRC_DEPTH = 16;

  typedef struct packed {
    logic [RW-1:0] rs;
    logic [OW-1:0] val;
  } item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          result_valid [UNITS];
  logic          result_ready [UNITS];
  logic [RW-1:0] result_rs_id [UNITS];
  logic [OW-1:0] result_value [UNITS];
  logic          cdb_valid;
  logic [RW-1:0] cdb_rs_id;
  logic [OW-1:0] cdb_value;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .UNITS(UNITS),
    .OPERAND_WIDTH(OW),
    .RS_ID_WIDTH(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_rs_id(result_rs_id),
    .result_value(result_value),
    .cdb_valid(cdb_valid),
    .cdb_rs_id(cdb_rs_id),
    .cdb_value(cdb_value)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard of broadcasts the bus still owes.
  item_t exp_q [$];

  // Reference model of buffers, pointer and held bus payload.
  bit            m_full [UNITS];
  int            m_ptr;
  logic [RW-1:0] m_rs   [UNITS];
  logic [OW-1:0] m_val  [UNITS];
  logic [RW-1:0] m_last_rs;
  logic [OW-1:0] m_last_val;

  // Per-unit producers: a list of results offered in order.
  logic [RW-1:0] src_rs  [UNITS][SRC_DEPTH];
  logic [OW-1:0] src_val [UNITS][SRC_DEPTH];
  int            src_wr  [UNITS];
  int            src_rd  [UNITS];

  bit count_en;
  int bcast_cnt [UNITS];

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic addItem(input int u, input logic [RW-1:0] rs,
                         input logic [OW-1:0] val);
    if (src_wr[u] < SRC_DEPTH) begin
      src_rs[u][src_wr[u]]  = rs;
      src_val[u][src_wr[u]] = val;
      src_wr[u]++;
    end
  endtask

  // Present the head of each producer list, or nothing when it is drained.
  task automatic applyStimulus();
    for (int u = 0; u < UNITS; u++) begin
      if (src_rd[u] < src_wr[u]) begin
        result_valid[u] = 1'b1;
        result_rs_id[u] = src_rs[u][src_rd[u]];
        result_value[u] = src_val[u][src_rd[u]];
      end else begin
        result_valid[u] = 1'b0;
        result_rs_id[u] = '0;
        result_value[u] = '0;
      end
    end
  endtask

  // One clock cycle: check ready mid-cycle against the model, advance the
  // model, then compare the bus just after the rising edge.
  task automatic stepCycle();
    int    g;
    int    idx;
    int    k;
    bit    exp_rdy;
    bit    acc [UNITS];
    item_t e;
    applyStimulus();
    @(negedge clk);
    g = -1;
    for (int i = 0; i < UNITS; i++) begin
      idx = (m_ptr + i) % UNITS;
      if (g < 0 && m_full[idx]) g = idx;
    end
    for (int u = 0; u < UNITS; u++) begin
      exp_rdy = !m_full[u] || (g == u);
      checkOutput($sformatf("ready%0d", u), 64'(result_ready[u]), 64'(exp_rdy));
      acc[u] = result_valid[u] && exp_rdy;
    end
    if (g >= 0) begin
      e.rs  = m_rs[g];
      e.val = m_val[g];
      exp_q.push_back(e);
      m_ptr = (g + 1) % UNITS;
    end
    for (int u = 0; u < UNITS; u++) begin
      if (acc[u]) begin
        m_rs[u]  = result_rs_id[u];
        m_val[u] = result_value[u];
        src_rd[u]++;
      end
      m_full[u] = acc[u] || (m_full[u] && (g != u));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("cdb_valid", 64'(cdb_valid), 64'(1));
      checkOutput("cdb_rs_id", 64'(cdb_rs_id), 64'(e.rs));
      checkOutput("cdb_value", 64'(cdb_value), 64'(e.val));
      m_last_rs  = e.rs;
      m_last_val = e.val;
    end else begin
      checkOutput("cdb_idle", 64'(cdb_valid), 64'(0));
      checkOutput("cdb_rs_hold", 64'(cdb_rs_id), 64'(m_last_rs));
      checkOutput("cdb_value_hold", 64'(cdb_value), 64'(m_last_val));
    end
    if (count_en && cdb_valid) begin
      k = int'(cdb_rs_id) - 1;
      if (k >= 0 && k < UNITS) bcast_cnt[k]++;
    end
    applyStimulus();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Entered just after a rising edge; asserts reset between edges, checks
  // the asynchronous effect and releases before the next falling edge.
  task automatic resetDut();
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    checkOutput("rst_cdb_rs_id", 64'(cdb_rs_id), 64'(0));
    checkOutput("rst_cdb_value", 64'(cdb_value), 64'(0));
    for (int u = 0; u < UNITS; u++) begin
      checkOutput($sformatf("rst_ready%0d", u), 64'(result_ready[u]), 64'(1));
      m_full[u] = 1'b0;
      src_wr[u] = 0;
      src_rd[u] = 0;
    end
    m_ptr      = 0;
    m_last_rs  = '0;
    m_last_val = '0;
    exp_q.delete();
    applyStimulus();
    #1 rst = 1'b1;
  endtask

  initial begin
    for (int u = 0; u < UNITS; u++) begin
      src_wr[u]       = 0;
      src_rd[u]       = 0;
      bcast_cnt[u]    = 0;
      result_valid[u] = 1'b0;
      result_rs_id[u] = '0;
      result_value[u] = '0;
    end
    count_en = 1'b0;
    @(posedge clk);
    #1;
    resetDut();

    // Single result into an idle system: on the bus two cycles later.
    addItem(2, 5'd5, 32'hDEADBEEF);
    runCycles(4);

    // All units at once, two results each; later units wait for their grant.
    resetDut();
    for (int u = 0; u < UNITS; u++) begin
      addItem(u, RW'(u + 1), 32'h100 + OW'(u));
      addItem(u, RW'(u + 5), 32'h200 + OW'(u));
    end
    runCycles(12);

    // Saturation: every unit always has a result waiting.
    resetDut();
    for (int u = 0; u < UNITS; u++) begin
      for (int k = 0; k < 12; k++) addItem(u, RW'(u + 1), 32'h1000 * OW'(u + 1) + OW'(k));
      bcast_cnt[u] = 0;
    end
    runCycles(2);
    count_en = 1'b1;
    runCycles(40);
    count_en = 1'b0;
    for (int u = 0; u < UNITS; u++) begin
      checkOutput($sformatf("sat_count%0d", u), 64'(bcast_cnt[u]), 64'(10));
    end
    runCycles(12);

    // Single streaming unit: drain and reload in the same cycle.
    resetDut();
    addItem(0, 5'd7, 32'h10);
    addItem(0, 5'd7, 32'h11);
    addItem(0, 5'd7, 32'h12);
    runCycles(6);

    // Reset mid-operation with buffered results, then pointer restart.
    resetDut();
    addItem(0, 5'd9,  32'hA0);
    addItem(1, 5'd10, 32'hA1);
    addItem(3, 5'd11, 32'hA3);
    runCycles(2);
    resetDut();
    runCycles(10);
    addItem(3, 5'd12, 32'hB3);
    addItem(0, 5'd13, 32'hB0);
    runCycles(5);

    // Pointer wrap: pointer at 3 with units 0 and 3 full, then pointer at 1.
    resetDut();
    addItem(2, 5'd14, 32'hC2);
    runCycles(3);
    addItem(0, 5'd15, 32'hC0);
    addItem(3, 5'd16, 32'hC3);
    runCycles(4);
    addItem(0, 5'd17, 32'hD0);
    addItem(2, 5'd18, 32'hD2);
    runCycles(4);

    checkOutput("drain", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
